// File: rtl/dbf_pkg.sv
// Shared types and constants for the 24-channel DBF beam scheduler.
package dbf_pkg;
  localparam int CH_NUM        = 24;
  localparam int SUM_W         = 37;
  localparam int NUM_BEAMS_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_e;
endpackage

// File: rtl/dbf_valid_dly.sv
// Fixed DEPTH-cycle delay of a valid strobe; latency DEPTH cycles, no backpressure.
module dbf_valid_dly #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_vld,
  output logic out_vld
);
  logic [DEPTH-1:0] sr_q, sr_d;

  always_comb begin
    sr_d    = sr_q;
    sr_d[0] = in_vld;
    for (int i = 1; i < DEPTH; i++) begin
      sr_d[i] = sr_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr_q <= '0;
    else        sr_q <= sr_d;
  end

  assign out_vld = sr_q[DEPTH-1];
endmodule

// File: rtl/dbf_beam_sched.sv
// Beam scheduler: one weight read per beam, in-order result tagging; one beam/clock, snap_ready low while busy.
// Optional DBF_SCHED_STAT_EN adds frame_cnt/busy_cyc statistics ports.
module dbf_beam_sched #(
  parameter int NUM_BEAMS  = dbf_pkg::NUM_BEAMS_DEF,
  parameter int BEAM_W     = $clog2(NUM_BEAMS),
  parameter int WEIGHT_LAT = 2,
  parameter int SUM_W      = dbf_pkg::SUM_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              snap_valid,
  output logic              snap_ready,
  output logic              weight_rd,
  output logic [BEAM_W-1:0] weight_addr,
  output logic              add_in_valid,
  input  logic              add_out_valid,
  input  logic [SUM_W-1:0]  add_data,
  output logic              beam_valid,
  output logic [BEAM_W-1:0] beam_idx,
  output logic [SUM_W-1:0]  beam_data,
  output logic              frame_done,
  output logic              seq_err
`ifdef DBF_SCHED_STAT_EN
  ,
  output logic [15:0]       frame_cnt,
  output logic [31:0]       busy_cyc
`endif
);
  import dbf_pkg::*;

  // Return counter needs one extra bit to tell "all results back" from "last beam pending".
  localparam int CNT_W = BEAM_W + 1;
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(NUM_BEAMS - 1);
  localparam logic [BEAM_W-1:0] LAST_ADDR = BEAM_W'(NUM_BEAMS - 1);

  state_e             state_q, state_d;
  logic               snap_ready_q, snap_ready_d;
  logic [BEAM_W-1:0]  iss_cnt_q, iss_cnt_d;
  logic               weight_rd_q, weight_rd_d;
  logic [BEAM_W-1:0]  weight_addr_q, weight_addr_d;
  logic [CNT_W-1:0]   rst_idx_q, rst_idx_d;
  logic               beam_valid_q, beam_valid_d;
  logic [BEAM_W-1:0]  beam_idx_q, beam_idx_d;
  logic [SUM_W-1:0]   beam_data_q, beam_data_d;
  logic               frame_done_q, frame_done_d;
  logic               seq_err_q, seq_err_d;
  logic               accept, take;

  assign accept = snap_valid & snap_ready_q;
  assign take   = add_out_valid && (state_q != IDLE) && (rst_idx_q <= LAST_CNT);

  always_comb begin
    state_d       = state_q;
    iss_cnt_d     = iss_cnt_q;
    rst_idx_d     = rst_idx_q;
    beam_idx_d    = beam_idx_q;
    beam_data_d   = beam_data_q;
    seq_err_d     = seq_err_q;
    snap_ready_d  = (state_q == IDLE) && !accept;
    weight_rd_d   = (state_q == ISSUE);
    weight_addr_d = (state_q == ISSUE) ? iss_cnt_q : '0;
    beam_valid_d  = take;
    frame_done_d  = take && (rst_idx_q == LAST_CNT);

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = ISSUE;
          iss_cnt_d = '0;
          rst_idx_d = '0;
        end
      end
      ISSUE: begin
        iss_cnt_d = iss_cnt_q + 1'b1;
        if (iss_cnt_q == LAST_ADDR) begin
          state_d   = DRAIN;
          iss_cnt_d = '0;
        end
      end
      DRAIN: begin
        if (take && (rst_idx_q == LAST_CNT)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (take) begin
      rst_idx_d   = rst_idx_q + 1'b1;
      beam_idx_d  = rst_idx_q[BEAM_W-1:0];
      beam_data_d = add_data;
    end
    if (add_out_valid && !take) seq_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      snap_ready_q  <= 1'b0;
      iss_cnt_q     <= '0;
      weight_rd_q   <= 1'b0;
      weight_addr_q <= '0;
      rst_idx_q     <= '0;
      beam_valid_q  <= 1'b0;
      beam_idx_q    <= '0;
      beam_data_q   <= '0;
      frame_done_q  <= 1'b0;
      seq_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      snap_ready_q  <= snap_ready_d;
      iss_cnt_q     <= iss_cnt_d;
      weight_rd_q   <= weight_rd_d;
      weight_addr_q <= weight_addr_d;
      rst_idx_q     <= rst_idx_d;
      beam_valid_q  <= beam_valid_d;
      beam_idx_q    <= beam_idx_d;
      beam_data_q   <= beam_data_d;
      frame_done_q  <= frame_done_d;
      seq_err_q     <= seq_err_d;
    end
  end

  dbf_valid_dly #(.DEPTH(WEIGHT_LAT)) u_valid_dly (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (weight_rd_q),
    .out_vld (add_in_valid)
  );

  assign snap_ready  = snap_ready_q;
  assign weight_rd   = weight_rd_q;
  assign weight_addr = weight_addr_q;
  assign beam_valid  = beam_valid_q;
  assign beam_idx    = beam_idx_q;
  assign beam_data   = beam_data_q;
  assign frame_done  = frame_done_q;
  assign seq_err     = seq_err_q;

`ifdef DBF_SCHED_STAT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [31:0] busy_cyc_q, busy_cyc_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q + {15'd0, frame_done_d};
    busy_cyc_d  = busy_cyc_q;
    if ((state_q != IDLE) && (busy_cyc_q != 32'hFFFF_FFFF)) busy_cyc_d = busy_cyc_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
      busy_cyc_q  <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      busy_cyc_q  <= busy_cyc_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign busy_cyc  = busy_cyc_q;
`endif
endmodule

// File: tb/tb_dbf_beam_sched.sv
// Directed bench for dbf_beam_sched: 16-beam/2-latency instance plus a 2-beam/1-latency instance.
module tb_dbf_beam_sched;
  localparam int NB = 16;
  localparam int SW = 37;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n = 1'b0;
  logic          snap_valid = 1'b0, snap_ready, weight_rd, add_in_valid, add_out_valid;
  logic [3:0]    weight_addr, beam_idx;
  logic [SW-1:0] add_data, beam_data;
  logic          beam_valid, frame_done, seq_err;
  logic          snap_valid2 = 1'b0, snap_ready2, weight_rd2, add_in_valid2, add_out_valid2;
  logic [0:0]    weight_addr2, beam_idx2;
  logic [SW-1:0] add_data2, beam_data2;
  logic          beam_valid2, frame_done2, seq_err2;
  logic          inj = 1'b0;
`ifdef DBF_SCHED_STAT_EN
  logic [15:0] frame_cnt, frame_cnt2;
  logic [31:0] busy_cyc, busy_cyc2;
`endif

  dbf_beam_sched #(.NUM_BEAMS(16), .WEIGHT_LAT(2), .SUM_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .snap_valid(snap_valid), .snap_ready(snap_ready),
    .weight_rd(weight_rd), .weight_addr(weight_addr), .add_in_valid(add_in_valid),
    .add_out_valid(add_out_valid), .add_data(add_data), .beam_valid(beam_valid),
    .beam_idx(beam_idx), .beam_data(beam_data), .frame_done(frame_done), .seq_err(seq_err)
`ifdef DBF_SCHED_STAT_EN
    , .frame_cnt(frame_cnt), .busy_cyc(busy_cyc)
`endif
  );

  dbf_beam_sched #(.NUM_BEAMS(2), .WEIGHT_LAT(1), .SUM_W(SW)) dut2 (
    .clk(clk), .rst_n(rst_n), .snap_valid(snap_valid2), .snap_ready(snap_ready2),
    .weight_rd(weight_rd2), .weight_addr(weight_addr2), .add_in_valid(add_in_valid2),
    .add_out_valid(add_out_valid2), .add_data(add_data2), .beam_valid(beam_valid2),
    .beam_idx(beam_idx2), .beam_data(beam_data2), .frame_done(frame_done2), .seq_err(seq_err2)
`ifdef DBF_SCHED_STAT_EN
    , .frame_cnt(frame_cnt2), .busy_cyc(busy_cyc2)
`endif
  );

  function automatic logic [SW-1:0] data_of(input int k);
    if (k == 7) return 37'h1F_FFFF_FFFF;
    return {5'(k), 32'h1357_9BDF} + SW'(k);
  endfunction

  // One-cycle adders that return beams strictly in issue order.
  logic          m_vld, m2_vld;
  logic [SW-1:0] m_dat, m2_dat;
  int            m_k, m2_k;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_vld <= 1'b0; m_dat <= '0; m_k <= 0;
      m2_vld <= 1'b0; m2_dat <= '0; m2_k <= 0;
    end else begin
      m_vld  <= add_in_valid;
      m2_vld <= add_in_valid2;
      if (add_in_valid) begin
        m_dat <= data_of(m_k);
        m_k   <= (m_k == NB - 1) ? 0 : m_k + 1;
      end
      if (add_in_valid2) begin
        m2_dat <= data_of(m2_k + 20);
        m2_k   <= (m2_k == 1) ? 0 : m2_k + 1;
      end
    end
  end
  assign add_out_valid  = m_vld | inj;
  assign add_data       = m_dat;
  assign add_out_valid2 = m2_vld;
  assign add_data2      = m2_dat;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input int max_cyc);
    int n = 0;
    while (snap_ready !== 1'b1 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk("wait_ready", {63'd0, snap_ready}, 64'd1);
  endtask

  // Launch one snapshot; returns at the sample point of cycle 0.
  task automatic start_frame();
    wait_ready(100);
    snap_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    snap_valid = 1'b0;
  endtask

  typedef struct {
    logic       sv;
    logic       rdy;
    logic       wrd;
    logic [3:0] waddr;
    logic       aiv;
    logic       bv;
    logic [3:0] bidx;
    logic       fd;
  } vec_t;
  vec_t tbl [24];

  task automatic run_table(input string tag);
    for (int c = 0; c < 24; c++) begin
      if (c > 0) @(negedge clk);
      chk($sformatf("%s_rdy_c%0d", tag, c), {63'd0, snap_ready}, {63'd0, tbl[c].rdy});
      chk($sformatf("%s_wrd_c%0d", tag, c), {63'd0, weight_rd}, {63'd0, tbl[c].wrd});
      if (tbl[c].wrd) chk($sformatf("%s_waddr_c%0d", tag, c), {60'd0, weight_addr}, {60'd0, tbl[c].waddr});
      chk($sformatf("%s_aiv_c%0d", tag, c), {63'd0, add_in_valid}, {63'd0, tbl[c].aiv});
      chk($sformatf("%s_bv_c%0d", tag, c), {63'd0, beam_valid}, {63'd0, tbl[c].bv});
      if (tbl[c].bv) begin
        chk($sformatf("%s_bidx_c%0d", tag, c), {60'd0, beam_idx}, {60'd0, tbl[c].bidx});
        chk($sformatf("%s_bdat_c%0d", tag, c), {27'd0, beam_data}, {27'd0, data_of(int'(tbl[c].bidx))});
      end
      if (c == 12) chk($sformatf("%s_beam7_all_ones", tag), {27'd0, beam_data}, {27'd0, 37'h1F_FFFF_FFFF});
      chk($sformatf("%s_fd_c%0d", tag, c), {63'd0, frame_done}, {63'd0, tbl[c].fd});
      chk($sformatf("%s_seqerr_c%0d", tag, c), {63'd0, seq_err}, 64'd0);
      snap_valid = tbl[c].sv;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nfd, nbv;
    // Expected cycle map for 16 beams, weight latency 2, adder latency 1.
    for (int c = 0; c < 24; c++) begin
      tbl[c].sv    = 1'b0;
      tbl[c].rdy   = (c >= 21);
      tbl[c].wrd   = (c >= 1 && c <= 16);
      tbl[c].waddr = 4'(c - 1);
      tbl[c].aiv   = (c >= 3 && c <= 18);
      tbl[c].bv    = (c >= 5 && c <= 20);
      tbl[c].bidx  = 4'(c - 5);
      tbl[c].fd    = (c == 20);
    end

    repeat (3) @(negedge clk);
    chk("rst_snap_ready", {63'd0, snap_ready}, 64'd0);
    chk("rst_weight_rd", {63'd0, weight_rd}, 64'd0);
    chk("rst_add_in_valid", {63'd0, add_in_valid}, 64'd0);
    chk("rst_beam_valid", {63'd0, beam_valid}, 64'd0);
    chk("rst_beam_data", {27'd0, beam_data}, 64'd0);
    chk("rst_frame_done", {63'd0, frame_done}, 64'd0);
    chk("rst_seq_err", {63'd0, seq_err}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_release_ready", {63'd0, snap_ready}, 64'd1);

    start_frame();
    run_table("frame1");
`ifdef DBF_SCHED_STAT_EN
    chk("stat_busy_after_frame1", {32'd0, busy_cyc}, 64'd20);
    chk("stat_frames_after_frame1", {48'd0, frame_cnt}, 64'd1);
`endif

    // snap_valid held high: frames restart every NB+WL+4 = 22 cycles.
    wait_ready(100);
    snap_valid = 1'b1;
    @(posedge clk);
    nfd = 0;
    nbv = 0;
    for (int c = 0; c < 66; c++) begin
      @(negedge clk);
      if (beam_valid === 1'b1) nbv++;
      if (frame_done === 1'b1) begin
        chk($sformatf("b2b_fd%0d_cycle", nfd), 64'(c), 64'(20 + 22 * nfd));
        nfd++;
      end
      if (c == 21) chk("b2b_ready_c21", {63'd0, snap_ready}, 64'd1);
      if (c == 22) chk("b2b_wrd_c22", {63'd0, weight_rd}, 64'd0);
      if (c == 23) chk("b2b_wrd_c23", {60'd0, weight_rd, weight_addr}, 64'h10);
      if (c == 64) snap_valid = 1'b0;
    end
    chk("b2b_frames", 64'(nfd), 64'd3);
    chk("b2b_beams", 64'(nbv), 64'd48);
    chk("b2b_idle_ready", {63'd0, snap_ready}, 64'd1);
`ifdef DBF_SCHED_STAT_EN
    chk("stat_frames_after_b2b", {48'd0, frame_cnt}, 64'd4);
    chk("stat_busy_after_b2b", {32'd0, busy_cyc}, 64'd80);
`endif

    // Spurious adder result while idle.
    inj = 1'b1;
    @(negedge clk);
    inj = 1'b0;
    chk("spur_no_beam_valid", {63'd0, beam_valid}, 64'd0);
    chk("spur_seq_err", {63'd0, seq_err}, 64'd1);
    repeat (5) @(negedge clk);
    chk("spur_seq_err_sticky", {63'd0, seq_err}, 64'd1);
    chk("spur_still_no_beam", {63'd0, beam_valid}, 64'd0);
    rst_n = 1'b0;
    #1;
    chk("spur_cleared_by_reset", {63'd0, seq_err}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset at cycle 10 of a frame, then a clean frame.
    start_frame();
    repeat (10) @(negedge clk);
    chk("mid_pre_wrd", {63'd0, weight_rd}, 64'd1);
    chk("mid_pre_bv", {63'd0, beam_valid}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_snap_ready", {63'd0, snap_ready}, 64'd0);
    chk("mid_rst_weight_rd", {63'd0, weight_rd}, 64'd0);
    chk("mid_rst_weight_addr", {60'd0, weight_addr}, 64'd0);
    chk("mid_rst_add_in_valid", {63'd0, add_in_valid}, 64'd0);
    chk("mid_rst_beam_valid", {63'd0, beam_valid}, 64'd0);
    chk("mid_rst_beam_idx", {60'd0, beam_idx}, 64'd0);
    chk("mid_rst_beam_data", {27'd0, beam_data}, 64'd0);
    chk("mid_rst_frame_done", {63'd0, frame_done}, 64'd0);
`ifdef DBF_SCHED_STAT_EN
    chk("mid_rst_frame_cnt", {48'd0, frame_cnt}, 64'd0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    start_frame();
    run_table("after_rst");

    // Two beams, weight latency 1.
    while (snap_ready2 !== 1'b1) @(negedge clk);
    snap_valid2 = 1'b1;
    @(posedge clk);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 0) snap_valid2 = 1'b0;
      chk($sformatf("nb2_bv_c%0d", c), {63'd0, beam_valid2}, 64'(c == 4 || c == 5));
      if (c == 4 || c == 5) begin
        chk($sformatf("nb2_bidx_c%0d", c), {63'd0, beam_idx2}, 64'(c - 4));
        chk($sformatf("nb2_bdat_c%0d", c), {27'd0, beam_data2}, {27'd0, data_of(c - 4 + 20)});
      end
      chk($sformatf("nb2_fd_c%0d", c), {63'd0, frame_done2}, 64'(c == 5));
      chk($sformatf("nb2_rdy_c%0d", c), {63'd0, snap_ready2}, 64'(c >= 6));
      chk($sformatf("nb2_wrd_c%0d", c), {63'd0, weight_rd2}, 64'(c >= 1 && c <= 2));
      chk($sformatf("nb2_aiv_c%0d", c), {63'd0, add_in_valid2}, 64'(c >= 2 && c <= 3));
      if (c == 2) chk("nb2_waddr_c2", {63'd0, weight_addr2}, 64'd1);
    end
    chk("nb2_seq_err", {63'd0, seq_err2}, 64'd0);
`ifdef DBF_SCHED_STAT_EN
    chk("nb2_frame_cnt", {48'd0, frame_cnt2}, 64'd1);
    chk("nb2_busy_cyc", {32'd0, busy_cyc2}, 64'd5);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
